// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin arbiter requester agents.
package arb_pkg;

    // Requester FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // One-hot grant vectors for the 3-way arbiter, used by system-level tests.
    localparam logic [2:0] GNT0 = 3'b001;
    localparam logic [2:0] GNT1 = 3'b010;
    localparam logic [2:0] GNT2 = 3'b100;

endpackage

// File: rtl/req_fifo.sv
// Synchronous DEPTH x WIDTH job FIFO; pointers wrap modulo DEPTH (power of 2).
module req_fifo
    import arb_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/arb_requester.sv
// Requester-side agent: queues burst jobs and drives one arbiter request line.
module arb_requester
    import arb_pkg::*;
#(
    parameter int unsigned AW      = 8,
    parameter int unsigned LENW    = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [AW-1:0]          job_addr,
    input  logic [LENW-1:0]        job_len,
    output logic                   request,
    input  logic                   grant,
    output logic                   bus_beat,
    output logic [AW-1:0]          bus_addr,
    output logic                   bus_last,
    output logic                   done,
    output logic                   abort,
    output logic                   timeout_err,
    input  logic                   err_clr,
    output logic [$clog2(DEPTH):0] pending
);

    localparam int unsigned WCW = $clog2(TIMEOUT);

    arb_state_t        state, state_n;
    logic [AW-1:0]     base, base_n;
    logic [LENW-1:0]   len, len_n;
    logic [LENW-1:0]   beat_cnt, beat_n;
    logic [WCW-1:0]    wait_cnt, wait_n;
    logic              done_n, abort_n, err_n;
    logic              push, pop;
    logic              full, empty;
    logic [AW+LENW-1:0] head;

    assign job_ready = !full && rst_n;
    assign push      = job_valid && job_ready;

    req_fifo #(
        .WIDTH (AW + LENW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({job_addr, job_len}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (pending)
    );

    assign request  = (state == REQ);
    assign bus_beat = request && grant;
    assign bus_addr = base + AW'(beat_cnt);
    assign bus_last = request && (beat_cnt == len);

    // State, active-job and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            base        <= '0;
            len         <= '0;
            beat_cnt    <= '0;
            wait_cnt    <= '0;
            done        <= 1'b0;
            abort       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            base        <= base_n;
            len         <= len_n;
            beat_cnt    <= beat_n;
            wait_cnt    <= wait_n;
            done        <= done_n;
            abort       <= abort_n;
            timeout_err <= err_n;
        end
    end

    // Next-state, queue pop, counters and error flag.
    always_comb begin
        state_n = state;
        base_n  = base;
        len_n   = len;
        beat_n  = beat_cnt;
        wait_n  = wait_cnt;
        done_n  = 1'b0;
        abort_n = 1'b0;
        pop     = 1'b0;
        err_n   = timeout_err;
        if (err_clr) err_n = 1'b0;

        case (state)
            IDLE, GAP: begin
                if (!empty) begin
                    pop     = 1'b1;
                    base_n  = head[AW+LENW-1:LENW];
                    len_n   = head[LENW-1:0];
                    beat_n  = '0;
                    wait_n  = '0;
                    state_n = REQ;
                end else begin
                    state_n = IDLE;
                end
            end
            REQ: begin
                if (grant) begin
                    beat_n = beat_cnt + LENW'(1);
                    wait_n = '0;
                    if (beat_cnt == len) begin
                        state_n = GAP;
                        done_n  = 1'b1;
                    end
                end else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
                    // Abort sets the sticky flag after err_clr so a same-cycle set wins.
                    state_n = GAP;
                    abort_n = 1'b1;
                    err_n   = 1'b1;
                    wait_n  = '0;
                end else begin
                    wait_n = wait_cnt + WCW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: vector table plus multi-cycle sequences.
module tb_arb_requester;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       job_valid;
    logic       job_ready;
    logic [7:0] job_addr;
    logic [3:0] job_len;
    logic       request;
    logic       grant;
    logic       bus_beat;
    logic [7:0] bus_addr;
    logic       bus_last;
    logic       done;
    logic       abort;
    logic       timeout_err;
    logic       err_clr;
    logic [2:0] pending;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    arb_requester #(
        .AW      (8),
        .LENW    (4),
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_addr    (job_addr),
        .job_len     (job_len),
        .request     (request),
        .grant       (grant),
        .bus_beat    (bus_beat),
        .bus_addr    (bus_addr),
        .bus_last    (bus_last),
        .done        (done),
        .abort       (abort),
        .timeout_err (timeout_err),
        .err_clr     (err_clr),
        .pending     (pending)
    );

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [7:0] addr;
        logic [3:0] len;
        logic       grant;
        logic       clr;
        logic       ready;
        logic       req;
        logic       beat;
        logic [7:0] baddr;
        logic       last;
        logic       done;
        logic       abort;
        logic       err;
        logic [2:0] pend;
    } vec_t;

    vec_t v [16];
    logic pat [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rst_n     = v[i].rst_n;
            job_valid = v[i].valid;
            job_addr  = v[i].addr;
            job_len   = v[i].len;
            grant     = v[i].grant;
            err_clr   = v[i].clr;
            @(negedge clk);
            chk($sformatf("row%0d_ready", i), job_ready, v[i].ready);
            chk($sformatf("row%0d_request", i), request, v[i].req);
            chk($sformatf("row%0d_beat", i), bus_beat, v[i].beat);
            if (v[i].req) chk($sformatf("row%0d_addr", i), bus_addr, v[i].baddr);
            chk($sformatf("row%0d_last", i), bus_last, v[i].last);
            chk($sformatf("row%0d_done", i), done, v[i].done);
            chk($sformatf("row%0d_abort", i), abort, v[i].abort);
            chk($sformatf("row%0d_err", i), timeout_err, v[i].err);
            chk($sformatf("row%0d_pending", i), pending, v[i].pend);
            tick();
        end
    endtask

    // Grant must never arrive while the agent is not requesting.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && grant === 1'b1 && request !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_without_request: request=%0b required 1 at %0t", request, $time);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dones, aborts, gap, bad_pend, cnt, got, beats;
        logic prev_req;
        logic [2:0] last_pend;

        //          rst v  addr   len g  c | rdy req bt baddr lst dn ab er pend
        v[0]  = '{1'b1,1'b1,8'h10,4'd3,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,3'd0};
        v[1]  = '{1'b1,1'b0,8'h00,4'd0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,3'd1};
        v[2]  = '{1'b1,1'b0,8'h00,4'd0,1'b1,1'b0, 1'b1,1'b1,1'b1,8'h10,1'b0,1'b0,1'b0,1'b0,3'd0};
        v[3]  = '{1'b1,1'b0,8'h00,4'd0,1'b1,1'b0, 1'b1,1'b1,1'b1,8'h11,1'b0,1'b0,1'b0,1'b0,3'd0};
        v[4]  = '{1'b1,1'b0,8'h00,4'd0,1'b1,1'b0, 1'b1,1'b1,1'b1,8'h12,1'b0,1'b0,1'b0,1'b0,3'd0};
        v[5]  = '{1'b1,1'b0,8'h00,4'd0,1'b1,1'b0, 1'b1,1'b1,1'b1,8'h13,1'b1,1'b0,1'b0,1'b0,3'd0};
        v[6]  = '{1'b1,1'b0,8'h00,4'd0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0,3'd0};
        v[7]  = '{1'b1,1'b0,8'h00,4'd0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,3'd0};
        v[8]  = '{1'b1,1'b1,8'hFE,4'd3,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,3'd0};
        v[9]  = '{1'b1,1'b0,8'h00,4'd0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,3'd1};
        v[10] = '{1'b1,1'b0,8'h00,4'd0,1'b1,1'b0, 1'b1,1'b1,1'b1,8'hFE,1'b0,1'b0,1'b0,1'b0,3'd0};
        v[11] = '{1'b1,1'b0,8'h00,4'd0,1'b1,1'b0, 1'b1,1'b1,1'b1,8'hFF,1'b0,1'b0,1'b0,1'b0,3'd0};
        v[12] = '{1'b1,1'b0,8'h00,4'd0,1'b1,1'b0, 1'b1,1'b1,1'b1,8'h00,1'b0,1'b0,1'b0,1'b0,3'd0};
        v[13] = '{1'b1,1'b0,8'h00,4'd0,1'b1,1'b0, 1'b1,1'b1,1'b1,8'h01,1'b1,1'b0,1'b0,1'b0,3'd0};
        v[14] = '{1'b1,1'b0,8'h00,4'd0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0,3'd0};
        v[15] = '{1'b1,1'b0,8'h00,4'd0,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,3'd0};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset state, with a job offered during reset.
        rst_n = 1'b0; job_valid = 1'b1; job_addr = 8'hAA; job_len = 4'd1;
        grant = 1'b0; err_clr = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rst_ready", job_ready, 1'b0);
        chk("rst_request", request, 1'b0);
        chk("rst_pending", pending, 3'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_abort", abort, 1'b0);
        chk("rst_err", timeout_err, 1'b0);
        tick();

        // Single burst with continuous grant, then address wrap.
        run_rows(0, 15);

        // Interrupted grant: beats only on granted cycles.
        job_valid = 1'b1; job_addr = 8'h40; job_len = 4'd2;
        tick();
        job_valid = 1'b0;
        tick();
        beats = 0;
        for (int i = 0; i < 5; i++) begin
            grant = pat[i];
            @(negedge clk);
            chk($sformatf("intr%0d_beat", i), bus_beat, pat[i]);
            chk($sformatf("intr%0d_abort", i), abort, 1'b0);
            if (pat[i]) begin
                chk($sformatf("intr%0d_addr", i), bus_addr, 8'h40 + 8'(beats));
                chk($sformatf("intr%0d_last", i), bus_last, (beats == 2) ? 1'b1 : 1'b0);
            end
            tick();
            if (pat[i]) beats++;
        end
        grant = 1'b0;
        @(negedge clk);
        chk("intr_done", done, 1'b1);
        chk("intr_request", request, 1'b0);
        tick();

        // Back-to-back: five jobs, queue fills, one-cycle request gaps.
        for (int k = 0; k < 5; k++) begin
            job_valid = 1'b1; job_addr = 8'(32 + 16 * k); job_len = 4'd1;
            tick();
        end
        job_valid = 1'b0;
        @(negedge clk);
        chk("b2b_full_ready", job_ready, 1'b0);
        chk("b2b_full_pending", pending, 3'd4);
        tick();
        dones = 0; aborts = 0; gap = 0; bad_pend = 0; prev_req = 1'b1; last_pend = 3'd4;
        for (int cyc = 0; cyc < 200 && dones < 5; cyc++) begin
            grant = request;
            @(negedge clk);
            if (done) dones++;
            if (abort) aborts++;
            if (pending > last_pend) bad_pend++;
            last_pend = pending;
            if (!request) begin
                gap++;
            end else begin
                if (!prev_req) chk("b2b_gap_len", gap, 1);
                gap = 0;
            end
            prev_req = request;
            tick();
        end
        grant = 1'b0;
        chk("b2b_done_count", dones, 5);
        chk("b2b_abort_count", aborts, 0);
        chk("b2b_pending_monotonic", bad_pend, 0);
        chk("b2b_pending_final", pending, 3'd0);

        // Timeout with grant held low, then next queued job, then err_clr.
        job_valid = 1'b1; job_addr = 8'h50; job_len = 4'd5;
        tick();
        job_addr = 8'h60; job_len = 4'd0;
        tick();
        job_valid = 1'b0;
        cnt = 0; got = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (abort) begin
                got = 1;
                break;
            end
            if (request) cnt++;
            tick();
        end
        chk("to_abort_seen", got, 1);
        chk("to_req_cycles", cnt, 16);
        chk("to_request_low", request, 1'b0);
        chk("to_done_low", done, 1'b0);
        chk("to_err_set", timeout_err, 1'b1);
        chk("to_pending", pending, 3'd1);
        tick();
        grant = 1'b1;
        @(negedge clk);
        chk("to_next_request", request, 1'b1);
        chk("to_next_addr", bus_addr, 8'h60);
        chk("to_next_last", bus_last, 1'b1);
        tick();
        grant = 1'b0;
        @(negedge clk);
        chk("to_next_done", done, 1'b1);
        chk("to_err_sticky", timeout_err, 1'b1);
        tick();
        err_clr = 1'b1;
        @(negedge clk);
        chk("to_err_before_clr", timeout_err, 1'b1);
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        chk("to_err_cleared", timeout_err, 1'b0);
        tick();

        // Reset mid-burst with two jobs queued.
        job_valid = 1'b1; job_addr = 8'h70; job_len = 4'd3;
        tick();
        job_addr = 8'h80; job_len = 4'd0;
        tick();
        job_addr = 8'h90; grant = 1'b1;
        tick();
        job_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; grant = 1'b0;
        @(negedge clk);
        chk("mid_rst_request", request, 1'b0);
        chk("mid_rst_pending", pending, 3'd0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_abort", abort, 1'b0);
        tick();
        @(negedge clk);
        chk("mid_rst_request2", request, 1'b0);
        chk("mid_rst_done2", done, 1'b0);
        chk("mid_rst_abort2", abort, 1'b0);
        tick();
        run_rows(0, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
